// File: rtl/latrsnq_notifier_gen.sv
// Timing-check monitor that toggles the notifier of a latrsnq latch model on setup, pulse-width,
// recovery and RN/SETN both-low violations. Define LATRSNQ_NOTIFIER_CNT_EN to build VIOL_CNT.
module latrsnq_notifier_gen #(
    parameter int SETUP_CYC = 2,
    parameter int PW_CYC    = 3,
    parameter int REC_CYC   = 2,
    parameter int CNT_W     = 4
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             MON_E,
    input  logic             MON_D,
    input  logic             MON_RN,
    input  logic             MON_SETN,
    input  logic             CHK_EN,
    output logic             notifier,
    output logic             VIOL,
    output logic [3:0]       VIOL_FLAGS,
    output logic [CNT_W-1:0] VIOL_CNT
);
    typedef enum logic [1:0] {ST_INIT, ST_CLOSED, ST_OPEN} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] SETUP_TH = CNT_W'(SETUP_CYC);
    localparam logic [CNT_W-1:0] PW_TH    = CNT_W'(PW_CYC);
    localparam logic [CNT_W-1:0] REC_TH   = CNT_W'(REC_CYC);

    state_t           r_state;
    logic             r_prev_e;
    logic             r_prev_d;
    logic             r_prev_rn;
    logic             r_prev_setn;
    logic [CNT_W-1:0] r_d_age;
    logic [CNT_W-1:0] r_rel_age;
    logic [CNT_W-1:0] r_e_hi;

    logic             w_edge_det;
    logic             w_d_chg;
    logic             w_rel;
    logic             w_close;
    logic             w_report;
    logic [3:0]       w_flags;
    logic [CNT_W-1:0] w_d_age_nxt;
    logic [CNT_W-1:0] w_rel_age_nxt;
    logic [CNT_W-1:0] w_e_hi_nxt;

    // The first edge after reset only captures history; no change or release is inferred from it.
    always_comb begin
        w_edge_det = (r_state != ST_INIT);
        w_d_chg    = w_edge_det && (MON_D != r_prev_d);
        w_rel      = w_edge_det && ((MON_RN && !r_prev_rn) || (MON_SETN && !r_prev_setn));
        w_close    = (r_state == ST_OPEN) && r_prev_e && !MON_E;

        w_flags    = 4'b0000;
        w_flags[0] = w_close && ((r_d_age < SETUP_TH) || w_d_chg);
        w_flags[1] = w_close && (r_e_hi < PW_TH);
        w_flags[2] = w_close && ((r_rel_age < REC_TH) || w_rel);
        w_flags[3] = w_edge_det && !MON_RN && !MON_SETN && (r_prev_rn || r_prev_setn);
        w_report   = CHK_EN && (w_flags != 4'b0000);

        w_d_age_nxt   = w_d_chg ? '0 : ((r_d_age == CNT_MAX) ? CNT_MAX : r_d_age + CNT_ONE);
        w_rel_age_nxt = w_rel ? '0 : ((r_rel_age == CNT_MAX) ? CNT_MAX : r_rel_age + CNT_ONE);
        w_e_hi_nxt    = !MON_E ? '0 : ((r_e_hi == CNT_MAX) ? CNT_MAX : r_e_hi + CNT_ONE);
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_state     <= ST_INIT;
            r_prev_e    <= 1'b0;
            r_prev_d    <= 1'b0;
            r_prev_rn   <= 1'b0;
            r_prev_setn <= 1'b0;
            r_d_age     <= CNT_MAX;
            r_rel_age   <= CNT_MAX;
            r_e_hi      <= '0;
            notifier    <= 1'b0;
            VIOL        <= 1'b0;
            VIOL_FLAGS  <= 4'b0000;
        end else begin
            r_prev_e    <= MON_E;
            r_prev_d    <= MON_D;
            r_prev_rn   <= MON_RN;
            r_prev_setn <= MON_SETN;
            r_d_age     <= w_d_age_nxt;
            r_rel_age   <= w_rel_age_nxt;
            r_e_hi      <= w_e_hi_nxt;

            case (r_state)
                ST_INIT:   r_state <= MON_E ? ST_OPEN : ST_CLOSED;
                ST_CLOSED: if (MON_E) r_state <= ST_OPEN;
                ST_OPEN:   if (!MON_E) r_state <= ST_CLOSED;
                default:   r_state <= ST_INIT;
            endcase

            VIOL <= w_report;
            if (w_report) begin
                notifier   <= ~notifier;
                VIOL_FLAGS <= w_flags;
            end
        end
    end

`ifdef LATRSNQ_NOTIFIER_CNT_EN
    logic [CNT_W-1:0] r_viol_cnt;

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_viol_cnt <= '0;
        end else if (w_report && (r_viol_cnt != CNT_MAX)) begin
            r_viol_cnt <= r_viol_cnt + CNT_ONE;
        end
    end

    assign VIOL_CNT = r_viol_cnt;
`else
    assign VIOL_CNT = '0;
`endif

endmodule

// File: tb/tb_latrsnq_notifier_gen.sv
// Self-checking bench for latrsnq_notifier_gen: directed scenarios plus randomized traffic
// checked against a sample-history reference model.
module tb_latrsnq_notifier_gen;
    localparam int SETUP_CYC = 2;
    localparam int PW_CYC    = 3;
    localparam int REC_CYC   = 2;
    localparam int CNT_W     = 4;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;
`ifdef LATRSNQ_NOTIFIER_CNT_EN
    localparam bit CNT_BUILT = 1'b1;
`else
    localparam bit CNT_BUILT = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             RN = 1'b0;
    logic             MON_E = 1'b0;
    logic             MON_D = 1'b0;
    logic             MON_RN = 1'b1;
    logic             MON_SETN = 1'b1;
    logic             CHK_EN = 1'b1;
    logic             notifier;
    logic             VIOL;
    logic [3:0]       VIOL_FLAGS;
    logic [CNT_W-1:0] VIOL_CNT;

    latrsnq_notifier_gen #(
        .SETUP_CYC(SETUP_CYC), .PW_CYC(PW_CYC), .REC_CYC(REC_CYC), .CNT_W(CNT_W)
    ) dut (
        .CLK(CLK), .RN(RN), .MON_E(MON_E), .MON_D(MON_D), .MON_RN(MON_RN),
        .MON_SETN(MON_SETN), .CHK_EN(CHK_EN), .notifier(notifier), .VIOL(VIOL),
        .VIOL_FLAGS(VIOL_FLAGS), .VIOL_CNT(VIOL_CNT)
    );

    always #5 CLK = ~CLK;

    // Stimulus values applied by the next step.
    logic cur_e = 1'b0, cur_d = 1'b0, cur_rn = 1'b1, cur_setn = 1'b1, cur_en = 1'b1;

    // Reference model: every sample seen since the last reset, plus expected outputs.
    bit               e_q[$], d_q[$], rn_q[$], setn_q[$];
    logic             exp_notifier = 1'b0;
    logic             exp_viol = 1'b0;
    logic [3:0]       exp_flags = 4'b0000;
    logic [CNT_W-1:0] exp_cnt = '0;
    int               checks = 0;
    int               errors = 0;

    function automatic logic [3:0] model_flags();
        int       k;
        int       run;
        logic     close;
        logic [3:0] f;
        k = e_q.size() - 1;
        f = 4'b0000;
        if (k < 1) return f;
        close = e_q[k-1] && !e_q[k];
        // a data change or release within the last N edges (counting this one) is too close
        for (int j = k; j >= 1 && (k - j) <= SETUP_CYC; j--)
            if (d_q[j] != d_q[j-1]) f[0] = close;
        run = 0;
        for (int j = k - 1; j >= 0 && e_q[j]; j--) run++;
        if (run > CNT_MAX) run = CNT_MAX;
        f[1] = close && (run < PW_CYC);
        for (int j = k; j >= 1 && (k - j) <= REC_CYC; j--)
            if ((rn_q[j] && !rn_q[j-1]) || (setn_q[j] && !setn_q[j-1])) f[2] = close;
        f[3] = !rn_q[k] && !setn_q[k] && (rn_q[k-1] || setn_q[k-1]);
        return f;
    endfunction

    task automatic model_clear();
        e_q.delete(); d_q.delete(); rn_q.delete(); setn_q.delete();
        exp_notifier = 1'b0;
        exp_viol     = 1'b0;
        exp_flags    = 4'b0000;
        exp_cnt      = '0;
    endtask

    task automatic step(input string tag);
        logic [3:0] f;
        MON_E = cur_e; MON_D = cur_d; MON_RN = cur_rn; MON_SETN = cur_setn; CHK_EN = cur_en;
        @(posedge CLK);
        #1;
        if (RN) begin
            e_q.push_back(cur_e); d_q.push_back(cur_d);
            rn_q.push_back(cur_rn); setn_q.push_back(cur_setn);
            f = model_flags();
            exp_viol = 1'b0;
            if (f != 4'b0000 && cur_en) begin
                exp_viol     = 1'b1;
                exp_notifier = ~exp_notifier;
                exp_flags    = f;
                if (CNT_BUILT && exp_cnt != CNT_W'(CNT_MAX)) exp_cnt = exp_cnt + 1'b1;
            end
        end
        checks++;
        if (notifier !== exp_notifier) begin
            errors++; $display("FAIL %s notifier got %0b want %0b", tag, notifier, exp_notifier);
        end
        checks++;
        if (VIOL !== exp_viol) begin
            errors++; $display("FAIL %s VIOL got %0b want %0b", tag, VIOL, exp_viol);
        end
        checks++;
        if (VIOL_FLAGS !== exp_flags) begin
            errors++; $display("FAIL %s VIOL_FLAGS got %b want %b", tag, VIOL_FLAGS, exp_flags);
        end
        checks++;
        if (VIOL_CNT !== exp_cnt) begin
            errors++; $display("FAIL %s VIOL_CNT got %0d want %0d", tag, VIOL_CNT, exp_cnt);
        end
    endtask

    task automatic idle(input int n, input string tag);
        cur_e = 1'b0;
        for (int i = 0; i < n; i++) step(tag);
    endtask

    // Asserts reset between clock edges and checks that outputs clear without a clock edge.
    task automatic apply_reset(input string tag);
        #2;
        RN = 1'b0;
        #1;
        model_clear();
        checks++;
        if ({notifier, VIOL, VIOL_FLAGS, VIOL_CNT} !== '0) begin
            errors++;
            $display("FAIL %s async clear got n=%0b v=%0b f=%b c=%0d want all 0",
                     tag, notifier, VIOL, VIOL_FLAGS, VIOL_CNT);
        end
        @(posedge CLK);
        @(posedge CLK);
        #3;
        RN = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({notifier, VIOL, VIOL_FLAGS, VIOL_CNT} !== '0) begin
            errors++;
            $display("FAIL reset_state got n=%0b v=%0b f=%b c=%0d want all 0",
                     notifier, VIOL, VIOL_FLAGS, VIOL_CNT);
        end
        @(posedge CLK);
        #3;
        RN = 1'b1;
        idle(3, "reset_idle");
    endtask

    task automatic test_clean();
        cur_d = ~cur_d;
        step("clean_d");
        cur_e = 1'b1;
        for (int i = 0; i < 5; i++) step("clean_open");
        cur_e = 1'b0;
        step("clean_close");
        checks++;
        if (VIOL !== 1'b0 || VIOL_FLAGS !== 4'b0000 || notifier !== 1'b0) begin
            errors++;
            $display("FAIL clean_summary got v=%0b f=%b n=%0b want 0 0000 0", VIOL, VIOL_FLAGS, notifier);
        end
        idle(2, "clean_idle");
    endtask

    task automatic test_setup();
        logic n0;
        idle(3, "setup_idle");
        n0 = exp_notifier;
        cur_e = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) cur_d = ~cur_d;
            step("setup_open");
        end
        cur_e = 1'b0;
        step("setup_close");
        checks++;
        if (VIOL !== 1'b1 || VIOL_FLAGS !== 4'b0001 || notifier !== ~n0) begin
            errors++;
            $display("FAIL setup_hit got v=%0b f=%b n=%0b want 1 0001 %0b", VIOL, VIOL_FLAGS, notifier, ~n0);
        end
        step("setup_after");
        checks++;
        if (VIOL !== 1'b0) begin
            errors++; $display("FAIL setup_pulse got VIOL=%0b want 0", VIOL);
        end
    endtask

    task automatic test_pulse_width();
        idle(4, "pw_idle");
        cur_e = 1'b1;
        step("pw_open");
        step("pw_open");
        cur_e = 1'b0;
        step("pw_close");
        checks++;
        if (VIOL !== 1'b1 || VIOL_FLAGS !== 4'b0010) begin
            errors++; $display("FAIL pw_hit got v=%0b f=%b want 1 0010", VIOL, VIOL_FLAGS);
        end
        idle(2, "pw_idle2");
    endtask

    task automatic test_recovery();
        // release two edges before close: too close
        cur_rn = 1'b0;
        idle(2, "rec_hold");
        cur_e = 1'b1;
        for (int i = 0; i < 3; i++) step("rec_open");
        cur_rn = 1'b1;
        step("rec_release");
        step("rec_open2");
        cur_e = 1'b0;
        step("rec_close");
        checks++;
        if (VIOL !== 1'b1 || VIOL_FLAGS !== 4'b0100) begin
            errors++; $display("FAIL rec_hit got v=%0b f=%b want 1 0100", VIOL, VIOL_FLAGS);
        end
        // release three edges before close: allowed
        cur_rn = 1'b0;
        idle(2, "rec_hold2");
        cur_e = 1'b1;
        for (int i = 0; i < 3; i++) step("rec_open3");
        cur_rn = 1'b1;
        step("rec_release2");
        step("rec_open4");
        step("rec_open5");
        cur_e = 1'b0;
        step("rec_close_ok");
        checks++;
        if (VIOL !== 1'b0) begin
            errors++; $display("FAIL rec_ok got VIOL=%0b want 0", VIOL);
        end
        // release on the closing edge itself
        cur_setn = 1'b0;
        idle(2, "rec_hold3");
        cur_e = 1'b1;
        for (int i = 0; i < 4; i++) step("rec_open6");
        cur_e = 1'b0;
        cur_setn = 1'b1;
        step("rec_same_edge");
        checks++;
        if (VIOL !== 1'b1 || VIOL_FLAGS !== 4'b0100) begin
            errors++; $display("FAIL rec_same got v=%0b f=%b want 1 0100", VIOL, VIOL_FLAGS);
        end
        idle(4, "rec_idle");
    endtask

    task automatic test_both_low();
        logic n0;
        n0 = exp_notifier;
        cur_rn = 1'b0;
        cur_setn = 1'b0;
        step("both_entry");
        checks++;
        if (notifier !== ~n0 || VIOL_FLAGS !== 4'b1000) begin
            errors++; $display("FAIL both_entry got n=%0b f=%b want %0b 1000", notifier, VIOL_FLAGS, ~n0);
        end
        for (int i = 0; i < 5; i++) step("both_hold");
        checks++;
        if (notifier !== ~n0) begin
            errors++; $display("FAIL both_sustain got n=%0b want %0b", notifier, ~n0);
        end
        cur_rn = 1'b1;
        cur_setn = 1'b1;
        idle(4, "both_idle");
    endtask

    task automatic test_suppress();
        logic n0;
        logic [CNT_W-1:0] c0;
        n0 = exp_notifier;
        c0 = exp_cnt;
        cur_en = 1'b0;
        cur_e = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) cur_d = ~cur_d;
            step("sup_open");
        end
        cur_e = 1'b0;
        step("sup_close");
        checks++;
        if (notifier !== n0 || VIOL !== 1'b0 || VIOL_CNT !== c0) begin
            errors++;
            $display("FAIL sup_hit got n=%0b v=%0b c=%0d want %0b 0 %0d", notifier, VIOL, VIOL_CNT, n0, c0);
        end
        cur_en = 1'b1;
        idle(3, "sup_idle");
    endtask

    task automatic test_reset_mid();
        cur_e = 1'b1;
        step("rst_open");
        step("rst_open");
        apply_reset("rst_mid");
        cur_e = 1'b0;
        step("rst_init_edge");
        checks++;
        if (VIOL !== 1'b0) begin
            errors++; $display("FAIL rst_no_false_close got VIOL=%0b want 0", VIOL);
        end
        idle(2, "rst_idle");
    endtask

    task automatic test_saturation();
        logic [CNT_W-1:0] want;
        want = CNT_BUILT ? CNT_W'(CNT_MAX) : '0;
        for (int i = 0; i < 17; i++) begin
            cur_e = 1'b1;
            step("sat_open");
            cur_e = 1'b0;
            step("sat_close");
        end
        checks++;
        if (VIOL_CNT !== want) begin
            errors++; $display("FAIL sat_count got %0d want %0d", VIOL_CNT, want);
        end
        idle(2, "sat_idle");
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) cur_e = ~cur_e;
            if ($urandom_range(0, 3) == 0) cur_d = ~cur_d;
            cur_rn   = ($urandom_range(0, 9) != 0);
            cur_setn = ($urandom_range(0, 9) != 0);
            cur_en   = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 99) == 0) apply_reset("rand_reset");
            step("random");
        end
        cur_rn = 1'b1;
        cur_setn = 1'b1;
        cur_en = 1'b1;
        idle(3, "rand_idle");
    endtask

    initial begin
        model_clear();
        test_reset();
        test_clean();
        test_setup();
        test_pulse_width();
        test_recovery();
        test_both_low();
        test_suppress();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
